// File: rtl/pll_reconfig_ctrl.sv
// Reconfiguration sequencer for the Gowin rPLL with dynamic IDSEL/FBDSEL/ODSEL, clocked from CLKIN.
// Optional macro PLLCTL_AUTO_RELOCK_EN: a lock drop while locked re-runs the PLL reset instead of failing.
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 256,
  parameter int         LOCK_TIMEOUT = 2400000,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] BOOT_IDIV    = 6'd5,
  parameter logic [5:0] BOOT_FBDIV   = 6'd22,
  parameter logic [5:0] BOOT_ODSEL   = 6'd60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [5:0] cfg_idiv,
  input  logic [5:0] cfg_fbdiv,
  input  logic [5:0] cfg_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       busy,
  output logic       locked,
  output logic       error,
  output logic [1:0] retry_cnt
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int ST_W  = $clog2(LOCK_STABLE + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int AT_W  = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [AT_W-1:0]  AT_LAST  = AT_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLLRST,
    S_WAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [RST_W-1:0] rst_cnt;
  logic [ST_W-1:0]  stab_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [AT_W-1:0]  att_cnt;

  logic             pend_valid;
  logic [5:0]       pend_idiv;
  logic [5:0]       pend_fbdiv;
  logic [5:0]       pend_odsel;

  // LOCK comes from the PLL's own analog domain; two flops before any decision.
  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  logic       stab_hit;
  logic       to_hit;
  logic       last_try;
  logic       seq_end;
  logic       idle_state;
  logic       busy_state;
  logic       start_new;
  logic [5:0] src_idiv;
  logic [5:0] src_fbdiv;
  logic [5:0] src_odsel;
  logic [1:0] retry_inc;

  // Lock qualification beats the timeout when both complete on the same cycle.
  assign stab_hit   = (state == S_WAIT) && lock_s && (stab_cnt == ST_LAST);
  assign to_hit     = (state == S_WAIT) && !stab_hit && (to_cnt == TO_LAST);
  assign last_try   = (att_cnt == AT_LAST);
  assign seq_end    = stab_hit || (to_hit && last_try);
  assign idle_state = (state == S_LOCKED) || (state == S_FAIL);
  assign busy_state = (state == S_PLLRST) || (state == S_WAIT);

  // A fresh request on the finishing cycle is newer than anything parked in the slot.
  assign start_new  = (req && idle_state) || (seq_end && (req || pend_valid));
  assign src_idiv   = req ? cfg_idiv  : pend_idiv;
  assign src_fbdiv  = req ? cfg_fbdiv : pend_fbdiv;
  assign src_odsel  = req ? cfg_odsel : pend_odsel;
  assign retry_inc  = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;

  // NOTE: reset is synchronous; every register, including the pending slot, has a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_PLLRST;
      rst_cnt    <= '0;
      stab_cnt   <= '0;
      to_cnt     <= '0;
      att_cnt    <= '0;
      retry_cnt  <= 2'd0;
      pll_reset  <= 1'b1;
      busy       <= 1'b1;
      locked     <= 1'b0;
      error      <= 1'b0;
      pll_idsel  <= ~BOOT_IDIV;
      pll_fbdsel <= ~BOOT_FBDIV;
      pll_odsel  <= BOOT_ODSEL;
      pend_valid <= 1'b0;
      pend_idiv  <= 6'd0;
      pend_fbdiv <= 6'd0;
      pend_odsel <= 6'd0;
    end else begin
      if (req && busy_state) begin
        pend_valid <= 1'b1;
        pend_idiv  <= cfg_idiv;
        pend_fbdiv <= cfg_fbdiv;
        pend_odsel <= cfg_odsel;
      end

      if (start_new) begin
        // Dividers are only ever loaded here, on entry to the PLL reset phase.
        state      <= S_PLLRST;
        rst_cnt    <= '0;
        att_cnt    <= '0;
        retry_cnt  <= 2'd0;
        pll_reset  <= 1'b1;
        busy       <= 1'b1;
        locked     <= 1'b0;
        error      <= 1'b0;
        pll_idsel  <= ~src_idiv;
        pll_fbdsel <= ~src_fbdiv;
        pll_odsel  <= src_odsel;
        pend_valid <= 1'b0;
      end else begin
        case (state)
          S_PLLRST: begin
            stab_cnt <= '0;
            to_cnt   <= '0;
            if (rst_cnt == RST_LAST) begin
              state     <= S_WAIT;
              pll_reset <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end

          S_WAIT: begin
            to_cnt   <= to_cnt + 1'b1;
            stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
            if (stab_hit) begin
              state  <= S_LOCKED;
              busy   <= 1'b0;
              locked <= 1'b1;
              error  <= 1'b0;
            end else if (to_hit) begin
              retry_cnt <= retry_inc;
              if (last_try) begin
                state     <= S_FAIL;
                busy      <= 1'b0;
                locked    <= 1'b0;
                error     <= 1'b1;
                pll_reset <= 1'b0;
              end else begin
                state     <= S_PLLRST;
                rst_cnt   <= '0;
                att_cnt   <= att_cnt + 1'b1;
                pll_reset <= 1'b1;
              end
            end
          end

          S_LOCKED: begin
            if (!lock_s) begin
`ifdef PLLCTL_AUTO_RELOCK_EN
              state     <= S_PLLRST;
              rst_cnt   <= '0;
              att_cnt   <= '0;
              retry_cnt <= 2'd0;
              pll_reset <= 1'b1;
              busy      <= 1'b1;
              locked    <= 1'b0;
`else
              state  <= S_FAIL;
              locked <= 1'b0;
              error  <= 1'b1;
`endif
            end
          end

          S_FAIL: begin
            // Hold the failed setting with the PLL out of reset until the next request.
            state <= S_FAIL;
          end

          default: begin
            state     <= S_PLLRST;
            rst_cnt   <= '0;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            error     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a small rPLL lock model driven on the falling clock edge.
// Expected cycle counts are derived from RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
module tb_pll_reconfig_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [5:0] cfg_idiv;
  logic [5:0] cfg_fbdiv;
  logic [5:0] cfg_odsel;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       busy;
  logic       locked;
  logic       error;
  logic [1:0] retry_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pll_reconfig_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(100),
    .MAX_RETRY   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cfg_idiv  (cfg_idiv),
    .cfg_fbdiv (cfg_fbdiv),
    .cfg_odsel (cfg_odsel),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_idsel (pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel (pll_odsel),
    .busy      (busy),
    .locked    (locked),
    .error     (error),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lock model: LOCK rises on the 10th falling edge after RESET is seen low.
  typedef enum {M_NORMAL, M_NEVER, M_MANUAL} mode_t;
  mode_t mode = M_NORMAL;
  int    lk_cnt = 0;

  always @(negedge clk) begin
    if (mode != M_MANUAL) begin
      if (pll_reset === 1'b1) begin
        lk_cnt   = 0;
        pll_lock = 1'b0;
      end else begin
        if (lk_cnt < 10) lk_cnt++;
        pll_lock = (mode == M_NORMAL) && (lk_cnt >= 10);
      end
    end
  end

  // Counts falling edges with pll_reset high, ending on the first low one.
  task automatic count_reset(output int n);
    n = 0;
    while (pll_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called on the first falling edge with pll_reset low; with the model above locked lands at k=20
  // (10 model cycles + 2 synchronizer stages + 8 stable samples).
  task automatic wait_locked(output int k);
    k = 1;
    while (locked !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic issue_req(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    req       = 1'b1;
    cfg_idiv  = i;
    cfg_fbdiv = f;
    cfg_odsel = o;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (locked !== 1'b0 || error !== 1'b0) begin n_err++; $display("FAIL reset_flags: got locked=%b error=%b want 0 0", locked, error); end
    n_cmp++; if (retry_cnt !== 2'd0) begin n_err++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (pll_idsel !== 6'h3A || pll_fbdsel !== 6'h29 || pll_odsel !== 6'd60) begin
      n_err++; $display("FAIL reset_dividers: got %h %h %0d want 3a 29 60", pll_idsel, pll_fbdsel, pll_odsel);
    end
  endtask

  task automatic test_boot;
    int n, k;
    rst_n = 1'b1;
    count_reset(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL boot_reset_len: got %0d want 4", n); end
    wait_locked(k);
    n_cmp++; if (k !== 20) begin n_err++; $display("FAIL boot_lock_latency: got %0d want 20", k); end
    n_cmp++; if (busy !== 1'b0 || error !== 1'b0 || retry_cnt !== 2'd0) begin
      n_err++; $display("FAIL boot_status: got busy=%b error=%b retry=%0d want 0 0 0", busy, error, retry_cnt);
    end
    n_cmp++; if (pll_idsel !== 6'h3A || pll_fbdsel !== 6'h29) begin
      n_err++; $display("FAIL boot_dividers: got %h %h want 3a 29", pll_idsel, pll_fbdsel);
    end
  endtask

  task automatic test_reconfig;
    int n, k;
    issue_req(6'd3, 6'd30, 6'd40);
    n_cmp++; if (pll_idsel !== 6'h3C || pll_fbdsel !== 6'h21 || pll_odsel !== 6'd40) begin
      n_err++; $display("FAIL reconfig_dividers: got %h %h %0d want 3c 21 40", pll_idsel, pll_fbdsel, pll_odsel);
    end
    n_cmp++; if (pll_reset !== 1'b1 || locked !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL reconfig_next: got reset=%b locked=%b busy=%b want 1 0 1", pll_reset, locked, busy);
    end
    count_reset(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL reconfig_reset_len: got %0d want 4", n); end
    wait_locked(k);
    n_cmp++; if (k !== 20) begin n_err++; $display("FAIL reconfig_lock_latency: got %0d want 20", k); end
    n_cmp++; if (pll_idsel !== 6'h3C || pll_odsel !== 6'd40) begin
      n_err++; $display("FAIL reconfig_hold: got %h %0d want 3c 40", pll_idsel, pll_odsel);
    end
  endtask

  task automatic test_glitch;
    int n, k;
    mode     = M_MANUAL;
    pll_lock = 1'b0;
    issue_req(6'd3, 6'd30, 6'd40);
    count_reset(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL glitch_reset_len: got %0d want 4", n); end
    @(negedge clk);
    pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    k = 0;
    while (locked !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    // 2 synchronizer stages + 8 stable samples after the final rise.
    n_cmp++; if (k !== 10) begin n_err++; $display("FAIL glitch_lock_latency: got %0d want 10", k); end
    mode = M_NORMAL;
  endtask

  task automatic test_queued;
    int j, rises;
    logic prev;
    req       = 1'b1;
    cfg_idiv  = 6'd1;
    cfg_fbdiv = 6'd10;
    cfg_odsel = 6'd20;
    @(negedge clk);
    req   = 1'b0;
    j     = 1;
    rises = 1;
    prev  = pll_reset;
    while (locked !== 1'b1 && j < 200) begin
      if (j == 3) begin
        req       = 1'b1;
        cfg_idiv  = 6'd2;
        cfg_fbdiv = 6'd16;
        cfg_odsel = 6'd30;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      j++;
      if (pll_reset === 1'b1 && prev === 1'b0) rises++;
      prev = pll_reset;
    end
    req = 1'b0;
    // A would lock at offset 24; B starts there and locks 23 cycles later.
    n_cmp++; if (j !== 47) begin n_err++; $display("FAIL queued_latency: got %0d want 47", j); end
    n_cmp++; if (rises !== 2) begin n_err++; $display("FAIL queued_reset_pulses: got %0d want 2", rises); end
    n_cmp++; if (pll_idsel !== 6'h3D || pll_fbdsel !== 6'h2F || pll_odsel !== 6'd30) begin
      n_err++; $display("FAIL queued_dividers: got %h %h %0d want 3d 2f 30", pll_idsel, pll_fbdsel, pll_odsel);
    end
  endtask

  task automatic test_timeout;
    int j, rh, n, k;
    logic [1:0] mid_retry;
    mode      = M_NEVER;
    mid_retry = 2'd0;
    req       = 1'b1;
    cfg_idiv  = 6'd4;
    cfg_fbdiv = 6'd20;
    cfg_odsel = 6'd50;
    @(negedge clk);
    req = 1'b0;
    j   = 1;
    rh  = 0;
    while (error !== 1'b1 && j < 400) begin
      if (pll_reset === 1'b1) rh++;
      if (j == 150) mid_retry = retry_cnt;
      @(negedge clk);
      j++;
    end
    // Two attempts of 4 reset + 100 wait cycles.
    n_cmp++; if (j !== 209) begin n_err++; $display("FAIL timeout_latency: got %0d want 209", j); end
    n_cmp++; if (rh !== 8) begin n_err++; $display("FAIL timeout_reset_cycles: got %0d want 8", rh); end
    n_cmp++; if (mid_retry !== 2'd1) begin n_err++; $display("FAIL timeout_mid_retry: got %0d want 1", mid_retry); end
    n_cmp++; if (retry_cnt !== 2'd2 || busy !== 1'b0 || pll_reset !== 1'b0 || locked !== 1'b0) begin
      n_err++; $display("FAIL timeout_status: got retry=%0d busy=%b reset=%b locked=%b want 2 0 0 0", retry_cnt, busy, pll_reset, locked);
    end
    n_cmp++; if (pll_idsel !== 6'h3B) begin n_err++; $display("FAIL timeout_hold: got %h want 3b", pll_idsel); end
    mode = M_NORMAL;
    issue_req(6'd3, 6'd30, 6'd40);
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 2'd0) begin
      n_err++; $display("FAIL fail_req_next: got error=%b busy=%b reset=%b retry=%0d want 0 1 1 0", error, busy, pll_reset, retry_cnt);
    end
    count_reset(n);
    wait_locked(k);
    n_cmp++; if (k !== 20) begin n_err++; $display("FAIL fail_req_relock: got %0d want 20", k); end
  endtask

  task automatic test_lock_loss;
    int n, k;
    mode     = M_MANUAL;
    pll_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL loss_sync_delay: got locked=%b want 1", locked); end
    mode = M_NORMAL;
    @(negedge clk);
`ifdef PLLCTL_AUTO_RELOCK_EN
    n_cmp++; if (pll_reset !== 1'b1 || busy !== 1'b1 || locked !== 1'b0 || retry_cnt !== 2'd0) begin
      n_err++; $display("FAIL loss_relock_start: got reset=%b busy=%b locked=%b retry=%0d want 1 1 0 0", pll_reset, busy, locked, retry_cnt);
    end
    count_reset(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL loss_reset_len: got %0d want 4", n); end
    wait_locked(k);
    n_cmp++; if (k !== 20) begin n_err++; $display("FAIL loss_relock_latency: got %0d want 20", k); end
`else
    n_cmp++; if (error !== 1'b1 || locked !== 1'b0 || busy !== 1'b0 || pll_reset !== 1'b0) begin
      n_err++; $display("FAIL loss_fail: got error=%b locked=%b busy=%b reset=%b want 1 0 0 0", error, locked, busy, pll_reset);
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pll_reset !== 1'b0) n++;
    end
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL loss_no_reset: got %0d reset cycles want 0", n); end
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL loss_error_hold: got %b want 1", error); end
    k = 0;
`endif
  endtask

  task automatic test_reset_mid;
    int n, k;
    issue_req(6'd3, 6'd30, 6'd40);
    @(negedge clk);
    issue_req(6'd1, 6'd2, 6'd3);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (pll_idsel !== 6'h3A || pll_fbdsel !== 6'h29 || pll_odsel !== 6'd60) begin
      n_err++; $display("FAIL midrst_dividers: got %h %h %0d want 3a 29 60", pll_idsel, pll_fbdsel, pll_odsel);
    end
    n_cmp++; if (pll_reset !== 1'b1 || busy !== 1'b1 || locked !== 1'b0 || error !== 1'b0) begin
      n_err++; $display("FAIL midrst_status: got reset=%b busy=%b locked=%b error=%b want 1 1 0 0", pll_reset, busy, locked, error);
    end
    rst_n = 1'b1;
    count_reset(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL midrst_reset_len: got %0d want 4", n); end
    wait_locked(k);
    n_cmp++; if (k !== 20) begin n_err++; $display("FAIL midrst_lock_latency: got %0d want 20", k); end
    n_cmp++; if (pll_idsel !== 6'h3A || pll_odsel !== 6'd60) begin
      n_err++; $display("FAIL midrst_pending_dropped: got %h %0d want 3a 60", pll_idsel, pll_odsel);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 1'b0;
    cfg_idiv  = 6'd0;
    cfg_fbdiv = 6'd0;
    cfg_odsel = 6'd0;
    pll_lock  = 1'b0;
    test_reset;
    test_boot;
    test_reconfig;
    test_glitch;
    test_queued;
    test_timeout;
    test_lock_loss;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequencer for the Gowin rPLL (GW1N-1) with dynamic IDIV/FBDIV/ODIV select enabled.
- Drives the PLL's RESET, IDSEL, FBDSEL and ODSEL; qualifies LOCK; retries on failure; reports status.
- Lets the VGA timing logic switch pixel clocks at run time without rebuilding the PLL IP.
- Runs on the crystal clock (the PLL's CLKIN domain, 24 MHz), never on a PLL output.

Parameters:
- RST_CYCLES, 16, cycles the PLL RESET is held high per attempt (≥2).
- LOCK_STABLE, 256, consecutive synchronized LOCK-high cycles required to declare lock.
- LOCK_TIMEOUT, 2400000, cycles after RESET release before the attempt fails (100 ms at 24 MHz).
- MAX_RETRY, 3, attempts per request before declaring failure (≥1).
- BOOT_IDIV, 5, IDIV setting applied after reset (divide = value+1).
- BOOT_FBDIV, 22, FBDIV setting applied after reset (multiply = value+1).
- BOOT_ODSEL, 6'd60, raw ODSEL code applied after reset.

Ports:
- clk, in, 1, crystal clock; same net as PLL CLKIN.
- rst_n, in, 1, synchronous active-low reset.
- req, in, 1, single-cycle request to apply cfg_*.
- cfg_idiv, in, 6, requested IDIV setting.
- cfg_fbdiv, in, 6, requested FBDIV setting.
- cfg_odsel, in, 6, requested raw ODSEL code.
- pll_lock, in, 1, PLL LOCK; asynchronous to clk.
- pll_reset, out, 1, to PLL RESET.
- pll_idsel, out, 6, to PLL IDSEL; equals ~idiv.
- pll_fbdsel, out, 6, to PLL FBDSEL; equals ~fbdiv.
- pll_odsel, out, 6, to PLL ODSEL; passed through unmodified.
- busy, out, 1, sequence in progress.
- locked, out, 1, PLL qualified locked on the current setting.
- error, out, 1, last request exhausted its retries.
- retry_cnt, out, 2, failed attempts for the current request.

Behaviour:
- pll_lock passes through a 2-flop synchronizer (lock_s); all decisions use lock_s.
- Reset (rst_n=0 at a clk edge), all outputs registered:
  - pll_reset=1, busy=1, locked=0, error=0, retry_cnt=0.
  - Divider registers load BOOT_* values; pll_idsel=~BOOT_IDIV, pll_fbdsel=~BOOT_FBDIV.
  - FSM enters PLLRST. The boot lock sequence needs no request.
- Divider registers change only on PLLRST entry. Their outputs are stable throughout WAIT, LOCKED and FAIL.
- FSM states:
  - IDLE: unused after reset; decodes to PLLRST.
  - PLLRST:
    - Outputs: pll_reset=1, busy=1, locked=0.
    - Counter runs 0..RST_CYCLES-1, then → WAIT.
  - WAIT:
    - Outputs: pll_reset=0, busy=1.
    - Timeout counter increments every cycle.
    - Stable counter increments while lock_s=1 and clears to 0 whenever lock_s=0.
    - Stable counter reaching LOCK_STABLE → LOCKED.
    - Else timeout counter reaching LOCK_TIMEOUT → retry_cnt+1. If retry_cnt+1 < MAX_RETRY → PLLRST; else → FAIL.
    - If stable and timeout complete in the same cycle, lock wins.
  - LOCKED:
    - Outputs: locked=1, busy=0, error=0.
    - retry_cnt keeps the value it had on entry.
  - FAIL:
    - Outputs: error=1, busy=0, locked=0, pll_reset=0.
    - Dividers hold the failed setting.
- Request acceptance:
  - req in LOCKED or FAIL: in that same cycle, cfg_* are captured into the divider registers, retry_cnt clears and the FSM enters PLLRST.
  - Timing: pll_reset and busy are high on the next cycle; locked and error are low on the next cycle.
- req while busy:
  - One pending slot; the latest cfg_* overwrite the slot.
  - The slot is serviced immediately on the cycle the current sequence would enter LOCKED or FAIL. The FSM goes straight to PLLRST, and locked/error are not asserted in between.
- Minimum request-to-locked latency: 1 + RST_CYCLES + 2 + LOCK_STABLE cycles.
- retry_cnt saturates at 3.
- Counters are sized by $clog2 of their limits; no wrap-around before the limit is reached.
- rst_n asserted mid-sequence: aborts immediately, discards the pending slot and restarts the boot sequence.

Optional Feature:
- Macro: PLLCTL_AUTO_RELOCK_EN.
- Defined:
  - In LOCKED, lock_s=0 for one cycle → PLLRST with unchanged dividers.
  - retry_cnt clears; busy=1 and locked=0 on the next cycle.
- Undefined:
  - In LOCKED, lock_s=0 → FAIL with error=1.
  - No PLL reset is issued until the next req.

Test Plan (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2):
- Boot: release rst_n; model asserts pll_lock 10 cycles after pll_reset falls.
  - pll_reset high exactly 4 cycles; pll_idsel=6'h3A, pll_fbdsel=6'h29.
  - locked=1 once lock_s has been high 8 cycles; busy=0; retry_cnt=0.
- Reconfig: in LOCKED, req with cfg_idiv=3, cfg_fbdiv=30, cfg_odsel=6'd40.
  - Next cycle: pll_idsel=6'h3C, pll_fbdsel=6'h21, pll_odsel=6'd40, pll_reset=1, locked=0.
  - Relock follows as in the boot case.
- Timeout/retry: model never locks.
  - Two attempts, each with 4 reset cycles plus 100 wait cycles.
  - Then error=1, retry_cnt=2, busy=0, pll_reset=0.
- Glitchy lock: in WAIT, pll_lock high 5 cycles, low 1, then high.
  - Stable count restarts; locked rises 8 cycles after the final rise (plus sync delay).
- Queued request: issue req A and, 3 cycles later, req B while busy.
  - A never reports locked; B's dividers are applied; locked=1 with B's settings.
- Lock loss: in LOCKED, drop pll_lock for 2 cycles.
  - With PLLCTL_AUTO_RELOCK_EN: pll_reset pulses 4 cycles, then relock.
  - Without: error=1 and pll_reset stays 0.
